ifetch_byte_sequencer: RTL and testbench

- Sequences the byte-wide instruction store: issues four single-byte reads per instruction and assembles the 32-bit word big-endian.
- Owns the PC and hands each instruction to the core over a valid/ready handshake.
- Sits between the core's next-PC logic (redirects) and the byte-addressed instruction memory.
- Flags out-of-range fetches.

---
 rtl/ifetch_byte_sequencer.sv | 107 ++++++++++
 tb/tb_ifetch_byte_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ifetch_byte_sequencer.sv
// ifetch_byte_sequencer: fetches 32-bit instructions as four big-endian byte reads and presents them over valid/ready
//   clk, rst_n        : clock, asynchronous active-low reset
//   mem_rd, mem_addr  : registered byte read strobe and address to the instruction store
//   mem_rdata         : byte returned for the read presented in the current cycle
//   redirect_valid/pc : load a new PC (highest priority, aborts any fetch in flight)
//   instr_valid/instr/instr_pc/instr_ready : instruction handshake to the core
//   misalign          : sticky, set when a redirect target is not word-aligned
//   fault             : fetch range error, sequencer halted until a redirect
module ifetch_byte_sequencer #(
  parameter int          MEM_BYTES = 256,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        misalign,
  output logic        fault
);
  typedef enum logic [2:0] {B0, B1, B2, B3, B4, HOLD, FAULT} state_t;
  state_t state, state_nx;
  logic [31:0] pc;
  logic [7:0] byte0, byte1, byte2;
  logic range_bad;
  // 33-bit compare so a PC near the top of the address space cannot wrap into range
  assign range_bad = ({1'b0, pc} + 33'd3) >= 33'(MEM_BYTES);
  always_comb begin
    state_nx = state;
    if (redirect_valid) state_nx = B0;
    else
      case (state)
        B0:      state_nx = range_bad ? FAULT : B1;
        B1:      state_nx = B2;
        B2:      state_nx = B3;
        B3:      state_nx = B4;
        B4:      state_nx = HOLD;
        HOLD:    state_nx = instr_ready ? B0 : HOLD;
        default: state_nx = state;
      endcase
  end
  // Each state's read is issued into the following cycle, where mem_rdata answers it;
  // B1..B4 therefore capture the bytes at pc..pc+3 while presenting the next address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= B0;
      pc          <= RESET_PC;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      misalign    <= 1'b0;
      fault       <= 1'b0;
      byte0       <= '0;
      byte1       <= '0;
      byte2       <= '0;
    end else begin
      state <= state_nx;
      if (redirect_valid) begin
        pc          <= {redirect_pc[31:2], 2'b00};
        mem_rd      <= 1'b0;
        instr_valid <= 1'b0;
        fault       <= 1'b0;
        if (|redirect_pc[1:0]) misalign <= 1'b1;
      end else
        case (state)
          B0:
            if (range_bad) fault <= 1'b1;
            else begin
              mem_rd   <= 1'b1;
              mem_addr <= pc;
            end
          B1: begin
            mem_addr <= pc + 32'd1;
            byte0    <= mem_rdata;
          end
          B2: begin
            mem_addr <= pc + 32'd2;
            byte1    <= mem_rdata;
          end
          B3: begin
            mem_addr <= pc + 32'd3;
            byte2    <= mem_rdata;
          end
          B4: begin
            mem_rd      <= 1'b0;
            instr       <= {byte0, byte1, byte2, mem_rdata};
            instr_pc    <= pc;
            instr_valid <= 1'b1;
          end
          HOLD:
            if (instr_ready) begin
              pc          <= pc + 32'd4;
              instr_valid <= 1'b0;
            end
          default: ;
        endcase
    end
  end
endmodule

// File: tb/tb_ifetch_byte_sequencer.sv
// tb_ifetch_byte_sequencer: directed table, corner-case sequences and random traffic against a fetch-age reference model
module tb_ifetch_byte_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_rd;
  logic [31:0] mem_addr;
  logic [7:0] mem_rdata;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic instr_valid;
  logic [31:0] instr, instr_pc;
  logic instr_ready = 1'b0;
  logic misalign, fault;
  logic [7:0] mem [256];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  assign mem_rdata = mem_rd ? mem[mem_addr[7:0]] : 8'h00;
  ifetch_byte_sequencer dut (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready), .misalign(misalign), .fault(fault)
  );
  typedef struct {
    logic        ready;
    logic        rd;
    logic [31:0] addr;
    logic        v;
    logic [31:0] ins;
    logic [31:0] ipc;
  } vec_t;
  vec_t tbl [21];
  // Model: the current fetch PC plus the number of cycles since that fetch began
  // (reset, redirect or handshake), saturating at 5 once the word is presented.
  logic [31:0] m_pc;
  int m_age;
  logic m_mis;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [7:0] i;
    i = a[7:0];
    return {mem[i], mem[i + 8'd1], mem[i + 8'd2], mem[i + 8'd3]};
  endfunction
  task automatic check_model;
    logic ok, erd;
    ok = m_pc <= 32'd252;
    erd = ok && m_age >= 1 && m_age <= 4;
    chk("mem_rd", {31'd0, mem_rd}, {31'd0, erd});
    if (erd) chk("mem_addr", mem_addr, m_pc + 32'(m_age) - 32'd1);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, ok && m_age == 5});
    if (ok && m_age == 5) begin
      chk("instr", instr, word_at(m_pc));
      chk("instr_pc", instr_pc, m_pc);
    end
    chk("fault", {31'd0, fault}, {31'd0, !ok && m_age >= 1});
    chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
  endtask
  task automatic tick;
    logic hs;
    @(posedge clk);
    hs = m_pc <= 32'd252 && m_age == 5 && instr_ready;
    if (redirect_valid) begin
      m_pc = {redirect_pc[31:2], 2'b00};
      m_age = 0;
      if (redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
    end else if (hs) begin
      m_pc = m_pc + 32'd4;
      m_age = 0;
    end else if (m_age < 5) m_age++;
    #1 check_model();
  endtask
  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc = t;
    tick();
    redirect_valid = 1'b0;
  endtask
  task automatic check_reset_values(input string tag);
    chk({tag, "_mem_rd"}, {31'd0, mem_rd}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_instr_pc"}, instr_pc, 32'd0);
    chk({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    {mem[0], mem[1], mem[2], mem[3]} = 32'h8C01_0004;
    {mem[4], mem[5], mem[6], mem[7]} = 32'h1122_3344;
    for (int i = 0; i < 4; i++) tbl[i] = '{1'b1, 1'b1, 32'(i), 1'b0, 32'h0, 32'h0};
    for (int i = 4; i < 15; i++) tbl[i] = '{1'b0, 1'b0, 32'd3, 1'b1, 32'h8C01_0004, 32'h0};
    tbl[15] = '{1'b1, 1'b0, 32'd3, 1'b0, 32'h0, 32'h0};
    for (int i = 16; i < 20; i++) tbl[i] = '{1'b0, 1'b1, 32'(i - 12), 1'b0, 32'h0, 32'h0};
    tbl[20] = '{1'b0, 1'b0, 32'd7, 1'b1, 32'h1122_3344, 32'h4};
    #12;
    check_reset_values("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 21; i++) begin
      instr_ready = tbl[i].ready;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_mem_rd", i), {31'd0, mem_rd}, {31'd0, tbl[i].rd});
      chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_instr_valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].v});
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_instr", i), instr, tbl[i].ins);
        chk($sformatf("tbl%0d_instr_pc", i), instr_pc, tbl[i].ipc);
      end
    end
    m_pc = 32'd4;
    m_age = 5;
    m_mis = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    chk("throughput_pc12", instr_pc, 32'd12);
    instr_ready = 1'b0;
    redirect(32'h0);
    tick();
    tick();
    redirect(32'h20);
    tick();
    chk("redirect_addr", mem_addr, 32'h20);
    for (int i = 0; i < 4; i++) tick();
    chk("redirect_instr_pc", instr_pc, 32'h20);
    instr_ready = 1'b1;
    redirect(32'h13);
    instr_ready = 1'b0;
    tick();
    chk("hs_redirect_addr", mem_addr, 32'h10);
    chk("hs_redirect_misalign", {31'd0, misalign}, 32'd1);
    instr_ready = 1'b1;
    redirect(32'hFD);
    for (int i = 0; i < 5; i++) tick();
    chk("top_fetch_pc", instr_pc, 32'hFC);
    tick();
    tick();
    chk("range_fault", {31'd0, fault}, 32'd1);
    tick();
    tick();
    redirect(32'h0);
    chk("fault_clear", {31'd0, fault}, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    instr_ready = 1'b0;
    redirect(32'h8);
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1 check_reset_values("async");
    m_pc = 32'h0;
    m_age = 0;
    m_mis = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("restart_instr", instr, 32'h8C01_0004);
    for (int i = 0; i < 3000; i++) begin
      redirect_valid = $urandom_range(15) == 0;
      case ($urandom_range(3))
        0: redirect_pc = 32'($urandom_range(255));
        1: redirect_pc = 32'hF0 + 32'($urandom_range(15));
        2: redirect_pc = 32'($urandom_range(511));
        default: redirect_pc = $urandom();
      endcase
      instr_ready = 1'($urandom_range(1));
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
